// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - 2x2 stride-2 max-pooling stage for a raster feature-map stream.
// Optional average pooling via `define POOL_AVG_EN (adds avg_mode input).
module pool2d_stream #(
  parameter int CH      = 16,
  parameter int DW      = 8,
  parameter int MAX_COL = 256,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pool_en,
  input  logic [CW-1:0]    cfg_col,
  input  logic [CW-1:0]    cfg_row,
`ifdef POOL_AVG_EN
  input  logic             avg_mode,
`endif
  input  logic             in_valid,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  output logic [CH*DW-1:0] out_data,
  output logic             frame_done,
  output logic             cfg_err
);

  localparam int AW = $clog2(MAX_COL / 2);
`ifdef POOL_AVG_EN
  localparam int EW = DW + 1;
`else
  localparam int EW = DW;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic               r_pool;
  logic               r_err_frm;
  logic [CW-1:0]      r_col_cfg;
  logic [CW-1:0]      r_row_cfg;
  logic [CW-1:0]      r_col_cnt;
  logic [CW-1:0]      r_row_cnt;
  logic [CH*DW-1:0]   r_h;
  logic               r_s1_vld;
  logic               r_s1_last;
  logic               r_s1_pool;
  logic [CH*DW-1:0]   r_s1_pix;
  logic [CH*EW-1:0]   r_s1_h;
  logic [CH*EW-1:0]   r_lb_q;
  logic [CH*EW-1:0]   r_lbuf [MAX_COL/2];
`ifdef POOL_AVG_EN
  logic               r_avg;
  logic               r_s1_avg;
`endif

  logic               w_start;
  logic               w_pool;
  logic               w_cfg_bad;
  logic               w_err;
  logic [CW-1:0]      w_col_cfg;
  logic [CW-1:0]      w_row_cfg;
  logic [CW-1:0]      w_col;
  logic [CW-1:0]      w_row;
  logic               w_col_last;
  logic               w_last;
  logic               w_emit;
  logic               w_lb_wr;
  logic [AW-1:0]      w_addr;
  logic [CH*EW-1:0]   w_hv;
  logic [CH*DW-1:0]   w_pooled;

  // A beat outside RUN opens a new frame and takes its config straight from the ports.
  assign w_start   = in_valid && (r_state != S_RUN);
  assign w_pool    = w_start ? pool_en : r_pool;
  assign w_col_cfg = w_start ? cfg_col : r_col_cfg;
  assign w_row_cfg = w_start ? cfg_row : r_row_cfg;
  assign w_col     = w_start ? '0 : r_col_cnt;
  assign w_row     = w_start ? '0 : r_row_cnt;
  assign w_cfg_bad = pool_en ? ((cfg_col < CW'(2)) || (cfg_row < CW'(2)) || (cfg_col > CW'(MAX_COL)))
                             : ((cfg_col == '0) || (cfg_row == '0));
  assign w_err     = w_start ? w_cfg_bad : r_err_frm;

  assign w_col_last = (w_col == w_col_cfg - CW'(1));
  assign w_last     = w_col_last && (w_row == w_row_cfg - CW'(1));
  assign w_addr     = w_col[AW:1];
  assign w_emit     = in_valid && !w_err && (w_pool ? (w_col[0] && w_row[0]) : 1'b1);
  assign w_lb_wr    = in_valid && !w_err && w_pool && w_col[0] && !w_row[0];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW-1:0] w_px;
    logic signed [DW-1:0] w_hp;
    logic signed [EW-1:0] w_a;
    logic signed [EW-1:0] w_b;
    assign w_px = in_data[c*DW +: DW];
    assign w_hp = r_h[c*DW +: DW];
    assign w_a  = r_s1_h[c*EW +: EW];
    assign w_b  = r_lb_q[c*EW +: EW];
`ifdef POOL_AVG_EN
    logic signed [EW:0] w_sum4;
    assign w_hv[c*EW +: EW] = r_avg ? (EW'(w_px) + EW'(w_hp))
                                    : ((w_px > w_hp) ? EW'(w_px) : EW'(w_hp));
    assign w_sum4 = (EW+1)'(w_a) + (EW+1)'(w_b);
    assign w_pooled[c*DW +: DW] = r_s1_avg ? DW'(w_sum4 >>> 2)
                                           : ((w_a > w_b) ? DW'(w_a) : DW'(w_b));
`else
    assign w_hv[c*EW +: EW]     = (w_px > w_hp) ? w_px : w_hp;
    assign w_pooled[c*DW +: DW] = (w_a > w_b) ? w_a : w_b;
`endif
  end

  // Line buffer is never reset: even rows always fill an entry before odd rows read it.
  always_ff @(posedge clk) begin
    if (w_lb_wr) r_lbuf[w_addr] <= w_hv;
    if (in_valid) r_lb_q <= r_lbuf[w_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pool     <= 1'b0;
      r_err_frm  <= 1'b0;
      r_col_cfg  <= '0;
      r_row_cfg  <= '0;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_h        <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_pool  <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_h     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef POOL_AVG_EN
      r_avg      <= 1'b0;
      r_s1_avg   <= 1'b0;
`endif
    end else begin
      if (in_valid) begin
        if (w_start) begin
          r_pool    <= pool_en;
          r_col_cfg <= cfg_col;
          r_row_cfg <= cfg_row;
          r_err_frm <= w_cfg_bad;
          cfg_err   <= cfg_err | w_cfg_bad;
`ifdef POOL_AVG_EN
          r_avg     <= avg_mode;
`endif
        end
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row + CW'(1);
        end else begin
          r_col_cnt <= w_col + CW'(1);
          r_row_cnt <= w_row;
        end
        if (!w_col[0]) r_h <= in_data;
        r_s1_pix  <= in_data;
        r_s1_h    <= w_hv;
        r_s1_pool <= w_pool;
`ifdef POOL_AVG_EN
        r_s1_avg  <= w_start ? avg_mode : r_avg;
`endif
        r_state   <= w_last ? S_DONE : S_RUN;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
      r_s1_vld   <= w_emit;
      r_s1_last  <= in_valid && w_last;
      out_valid  <= r_s1_vld;
      frame_done <= r_s1_last;
      if (r_s1_vld) out_data <= r_s1_pool ? w_pooled : r_s1_pix;
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// tb/tb_pool2d_stream.sv - directed self-checking bench for pool2d_stream.
module tb_pool2d_stream;
  localparam int CH = 16;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int W  = CH * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pool_en;
  logic [CW-1:0] cfg_col;
  logic [CW-1:0] cfg_row;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          frame_done;
  logic          cfg_err;
`ifdef POOL_AVG_EN
  logic          avg_mode;
`endif

  pool2d_stream #(.CH(CH), .DW(DW), .MAX_COL(256), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pool_en(pool_en), .cfg_col(cfg_col), .cfg_row(cfg_row),
`ifdef POOL_AVG_EN
    .avg_mode(avg_mode),
`endif
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]         mon_d[$];
  int                   mon_c[$];
  int                   fd_c[$];
  int                   bc[$];
  logic signed [DW-1:0] exp_v[$];
  int                   exp_b[$];
  int                   n_chk = 0;
  int                   n_err = 0;

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      mon_d.push_back(out_data);
      mon_c.push_back(cyc);
    end
    if (frame_done) fd_c.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic pe, input int c, input int r);
    pool_en = pe;
    cfg_col = CW'(c);
    cfg_row = CW'(r);
    mon_d.delete(); mon_c.delete(); fd_c.delete();
    bc.delete(); exp_v.delete(); exp_b.delete();
  endtask

  task automatic beat(input logic signed [DW-1:0] px);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {CH{px}};
    bc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic expect_out(input logic signed [DW-1:0] v, input int b);
    exp_v.push_back(v);
    exp_b.push_back(b);
  endtask

  task automatic verify(input string tag);
    chk({tag, ".count"}, W'(mon_d.size()), W'(exp_v.size()));
    for (int k = 0; k < exp_v.size(); k++) begin
      if (k < mon_d.size()) begin
        chk($sformatf("%s.data%0d", tag, k), mon_d[k], {CH{exp_v[k]}});
        chk($sformatf("%s.lat%0d", tag, k), W'(mon_c[k]), W'(bc[exp_b[k]] + 2));
      end
    end
    chk({tag, ".fd_count"}, W'(fd_c.size()), W'(1));
    if (fd_c.size() > 0 && bc.size() > 0)
      chk({tag, ".fd_cyc"}, W'(fd_c[0]), W'(bc[bc.size()-1] + 2));
  endtask

  initial begin
    logic signed [DW-1:0] bv [6];
    bv = '{8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50, -8'sd60};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; pool_en = 1'b1; cfg_col = '0; cfg_row = '0;
`ifdef POOL_AVG_EN
    avg_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.frame_done", W'(frame_done), W'(0));
    chk("rst.cfg_err", W'(cfg_err), W'(0));
    rst_n = 1'b1;

    start(1'b1, 4, 4);
    for (int i = 0; i < 16; i++) beat(DW'(i));
    idle(4);
    expect_out(8'sd5, 5); expect_out(8'sd7, 7); expect_out(8'sd13, 13); expect_out(8'sd15, 15);
    verify("p4x4");
    chk("p4x4.cfg_err", W'(cfg_err), W'(0));

    start(1'b1, 2, 2);
    beat(-8'sd128); beat(-8'sd1); beat(-8'sd5); beat(-8'sd100);
    idle(4);
    expect_out(-8'sd1, 3);
    verify("signed");

    start(1'b1, 5, 3);
    for (int i = 0; i < 15; i++) beat(DW'(i));
    idle(4);
    expect_out(8'sd6, 6); expect_out(8'sd8, 8);
    verify("p5x3");

    start(1'b1, 4, 4);
    for (int i = 0; i < 16; i++) begin
      beat(DW'(i));
      idle((i < 8) ? 1 : int'($urandom_range(0, 3)));
    end
    idle(4);
    expect_out(8'sd5, 5); expect_out(8'sd7, 7); expect_out(8'sd13, 13); expect_out(8'sd15, 15);
    verify("gaps");

    start(1'b0, 3, 2);
    for (int i = 0; i < 6; i++) begin
      beat(bv[i]);
      expect_out(bv[i], i);
    end
    idle(4);
    verify("bypass");
    chk("bypass.cfg_err", W'(cfg_err), W'(0));

    start(1'b1, 1, 2);
    beat(8'sd1); beat(8'sd2);
    idle(4);
    verify("cfgerr");
    chk("cfgerr.flag", W'(cfg_err), W'(1));

    start(1'b1, 4, 4);
    for (int i = 0; i < 6; i++) beat(DW'(i));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bc.delete();
    for (int i = 0; i < 16; i++) beat(DW'(100 + i));
    idle(4);
    expect_out(8'sd105, 5); expect_out(8'sd107, 7); expect_out(8'sd113, 13); expect_out(8'sd115, 15);
    verify("reset");
    chk("reset.cfg_err", W'(cfg_err), W'(0));

`ifdef POOL_AVG_EN
    avg_mode = 1'b1;
    start(1'b1, 2, 2);
    beat(8'sd4); beat(8'sd5); beat(8'sd6); beat(8'sd7);
    idle(4);
    expect_out(8'sd5, 3);
    verify("avg_pos");
    start(1'b1, 2, 2);
    beat(-8'sd1); beat(-8'sd2); beat(-8'sd2); beat(-8'sd2);
    idle(4);
    expect_out(-8'sd2, 3);
    verify("avg_neg");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
